rv32_branch_predictor: RTL and testbench

Parametrised branch predictor for the RV32 pipeline. It replaces the fixed "always predict not-taken, PC+4" fetch policy with a direct-mapped BTB holding saturating direction counters. IF looks up the current PC and gets a predicted next PC in the same cycle. EX reports each resolved branch; the block updates its tables, decides whether a mispredict occurred, and drives the redirect PC. Perf counters track lookups and mispredicts.

---
 rtl/rv32_pipeline_pkg.sv | 17 +
 rtl/rv32_branch_predictor_if.sv | 43 ++++
 rtl/rv32_branch_predictor_sat_counter.sv | 23 ++
 rtl/rv32_branch_predictor.sv | 125 ++++++++++++
 tb/tb_rv32_branch_predictor.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pipeline_pkg.sv
// rtl/rv32_pipeline_pkg.sv - shared RV32 pipeline types and helpers
// Purpose: prediction-mode enum and the sequential next-PC helper used by
//          the fetch-side branch predictor.
// Ports:   none (package).
package rv32_pipeline_pkg;

  typedef enum logic {
    PRED_STATIC_NT = 1'b0,
    PRED_BIMODAL   = 1'b1
  } pred_mode_e;

  // Fall-through PC; 32-bit add wraps 0xFFFFFFFC -> 0x00000000.
  function automatic logic [31:0] next_pc_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/rv32_branch_predictor_if.sv
// rtl/rv32_branch_predictor_if.sv - IF/EX <-> branch predictor signal bundle
// Purpose: groups the lookup, update, redirect and perf signals.
// Ports:   master = pipeline side (drives lookup_*/upd_*),
//          slave  = predictor side (drives pred_*/redirect_*/perf_*).
interface rv32_branch_predictor_if;
  import rv32_pipeline_pkg::*;

  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;

  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_next_pc;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] perf_lookups;
  logic [31:0] perf_mispredicts;

  modport master (
    output lookup_valid, lookup_pc,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_next_pc,
    input  pred_hit, pred_taken, pred_next_pc,
    input  redirect_valid, redirect_pc,
    input  perf_lookups, perf_mispredicts
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_next_pc,
    output pred_hit, pred_taken, pred_next_pc,
    output redirect_valid, redirect_pc,
    output perf_lookups, perf_mispredicts
  );

endinterface

// File: rtl/rv32_branch_predictor_sat_counter.sv
// rtl/rv32_branch_predictor_sat_counter.sv - saturating direction counter next-value
// Purpose: combinational next value of a CTR_BITS up/down saturating counter.
// Ports:   ctr (current value), taken (direction), ctr_next (saturated result).
module bp_sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr_next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) ctr_next = ctr + CTR_BITS'(1);
    end else begin
      if (ctr != '0) ctr_next = ctr - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/rv32_branch_predictor.sv
// rtl/rv32_branch_predictor.sv - direct-mapped bimodal BTB branch predictor
// Purpose: 0-cycle lookup of the fetch PC, registered table update from EX,
//          combinational mispredict redirect, lookup/mispredict perf counters.
// Ports:   clk, rst_n (sync active-low), bp (slave side of the predictor bundle).
module rv32_branch_predictor
  import rv32_pipeline_pkg::*;
#(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned TAG_BITS  = 8,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned PRED_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rv32_branch_predictor_if.slave  bp
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam pred_mode_e  MODE = pred_mode_e'(PRED_MODE[0]);
  localparam bit          BIMODAL = (MODE == PRED_BIMODAL);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(1) << (CTR_BITS - 1);

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [29:0]         target;
    logic [CTR_BITS-1:0] ctr;
  } btb_entry_t;

  btb_entry_t btb_q [ENTRIES];

  logic [31:0] perf_lookups_q, perf_lookups_d;
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

  // Lookup path
  logic [IDX-1:0]      lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  btb_entry_t          lk_entry;
  logic                lk_hit;
  logic                lk_taken;

  assign lk_idx   = bp.lookup_pc[IDX+1:2];
  assign lk_tag   = bp.lookup_pc[IDX+1+TAG_BITS:IDX+2];
  assign lk_entry = btb_q[lk_idx];

  // rst_n gate keeps outputs quiet during the reset cycle, before the clear lands.
  assign lk_hit   = BIMODAL & rst_n & bp.lookup_valid & lk_entry.valid &
                    (lk_entry.tag == lk_tag);
  assign lk_taken = lk_hit & lk_entry.ctr[CTR_BITS-1];

  assign bp.pred_hit     = lk_hit;
  assign bp.pred_taken   = lk_taken;
  assign bp.pred_next_pc = lk_taken ? {lk_entry.target, 2'b00} : next_pc_seq(bp.lookup_pc);

  // Update path
  logic [IDX-1:0]      upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  btb_entry_t          upd_entry;
  logic                upd_hit;
  logic [CTR_BITS-1:0] ctr_next;
  logic                wr_en;
  btb_entry_t          wr_entry_d;

  assign upd_idx   = bp.upd_pc[IDX+1:2];
  assign upd_tag   = bp.upd_pc[IDX+1+TAG_BITS:IDX+2];
  assign upd_entry = btb_q[upd_idx];
  assign upd_hit   = upd_entry.valid & (upd_entry.tag == upd_tag);

  bp_sat_counter #(.CTR_BITS(CTR_BITS)) u_sat_counter (
    .ctr      (upd_entry.ctr),
    .taken    (bp.upd_taken),
    .ctr_next (ctr_next)
  );

  always_comb begin
    wr_en      = 1'b0;
    wr_entry_d = upd_entry;
    if (BIMODAL && bp.upd_valid) begin
      if (upd_hit) begin
        wr_en          = 1'b1;
        wr_entry_d.ctr = ctr_next;
        if (bp.upd_taken) wr_entry_d.target = bp.upd_target[31:2];
      end else if (bp.upd_taken) begin
        // Taken miss allocates weakly-taken, evicting whatever aliased here.
        wr_en             = 1'b1;
        wr_entry_d.valid  = 1'b1;
        wr_entry_d.tag    = upd_tag;
        wr_entry_d.target = bp.upd_target[31:2];
        wr_entry_d.ctr    = CTR_WEAK_T;
      end
    end
  end

  // Redirect path
  logic [31:0] correct_pc;
  logic        redirect;

  assign correct_pc        = bp.upd_taken ? bp.upd_target : next_pc_seq(bp.upd_pc);
  assign redirect          = bp.upd_valid & (correct_pc != bp.upd_pred_next_pc);
  assign bp.redirect_valid = redirect;
  assign bp.redirect_pc    = correct_pc;

  assign perf_lookups_d     = perf_lookups_q + 32'(bp.lookup_valid);
  assign perf_mispredicts_d = perf_mispredicts_q + 32'(redirect);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) btb_q[i] <= '0;
      perf_lookups_q     <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      if (wr_en) btb_q[upd_idx] <= wr_entry_d;
      perf_lookups_q     <= perf_lookups_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign bp.perf_lookups     = perf_lookups_q;
  assign bp.perf_mispredicts = perf_mispredicts_q;

  // High PC bits, target[1:0] and the carried prediction bit are not needed here.
  logic unused_bits;
  assign unused_bits = ^{bp.lookup_pc, bp.upd_pc, bp.upd_target, bp.upd_pred_taken};

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// tb/tb_rv32_branch_predictor.sv - self-checking bench for rv32_branch_predictor
module tb_rv32_branch_predictor;

  logic clk;
  logic rst_n;

  rv32_branch_predictor_if bi_if ();
  rv32_branch_predictor_if st_if ();

  rv32_branch_predictor #(.ENTRIES(64), .TAG_BITS(8), .CTR_BITS(2), .PRED_MODE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bi_if)
  );

  rv32_branch_predictor #(.ENTRIES(64), .TAG_BITS(8), .CTR_BITS(2), .PRED_MODE(0)) dut_st (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (st_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        lv;
    logic [31:0] lpc;
    logic [33:0] lk;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] upnpc;
  } row_t;

  typedef struct {
    logic [33:0] lk;
    logic [32:0] up;
    logic [31:0] pl;
    logic [31:0] pm;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] m_look [2];
  logic [31:0] m_mis  [2];
  int          checks = 0;
  int          errors = 0;

  function automatic row_t mk(logic lv, logic [31:0] lpc, logic hit, logic tk, logic [31:0] npc,
                              logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                              logic [31:0] upnpc);
    row_t r;
    r.rn = 1'b1; r.lv = lv; r.lpc = lpc; r.lk = {hit, tk, npc};
    r.uv = uv; r.upc = upc; r.ut = ut; r.utgt = utgt; r.upnpc = upnpc;
    return r;
  endfunction

  function automatic row_t lk(logic [31:0] lpc, logic hit, logic tk, logic [31:0] npc);
    return mk(1'b1, lpc, hit, tk, npc, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endfunction

  function automatic row_t up(logic [31:0] upc, logic ut, logic [31:0] utgt, logic [31:0] upnpc);
    return mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b1, upc, ut, utgt, upnpc);
  endfunction

  function automatic row_t idle();
    return mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endfunction

  task automatic set_idle_st();
    st_if.lookup_valid = 1'b0; st_if.lookup_pc = 32'h0; st_if.upd_valid = 1'b0;
    st_if.upd_pc = 32'h0; st_if.upd_taken = 1'b0; st_if.upd_target = 32'h0;
    st_if.upd_pred_taken = 1'b0; st_if.upd_pred_next_pc = 32'h0;
  endtask

  task automatic set_idle_bi();
    bi_if.lookup_valid = 1'b0; bi_if.lookup_pc = 32'h0; bi_if.upd_valid = 1'b0;
    bi_if.upd_pc = 32'h0; bi_if.upd_taken = 1'b0; bi_if.upd_target = 32'h0;
    bi_if.upd_pred_taken = 1'b0; bi_if.upd_pred_next_pc = 32'h0;
  endtask

  // Drives one cycle at the falling edge and pushes what the outputs must show.
  task automatic drive(input int sel, input row_t r);
    exp_t        e;
    logic [31:0] correct;
    logic        rv;
    @(negedge clk);
    rst_n = r.rn;
    if (sel == 0) begin
      set_idle_st();
      bi_if.lookup_valid = r.lv; bi_if.lookup_pc = r.lpc; bi_if.upd_valid = r.uv;
      bi_if.upd_pc = r.upc; bi_if.upd_taken = r.ut; bi_if.upd_target = r.utgt;
      bi_if.upd_pred_next_pc = r.upnpc; bi_if.upd_pred_taken = (r.upnpc != r.upc + 32'd4);
    end else begin
      set_idle_bi();
      st_if.lookup_valid = r.lv; st_if.lookup_pc = r.lpc; st_if.upd_valid = r.uv;
      st_if.upd_pc = r.upc; st_if.upd_taken = r.ut; st_if.upd_target = r.utgt;
      st_if.upd_pred_next_pc = r.upnpc; st_if.upd_pred_taken = (r.upnpc != r.upc + 32'd4);
    end
    correct = r.ut ? r.utgt : r.upc + 32'd4;
    rv      = r.uv && (correct != r.upnpc);
    e.lk = r.lk; e.up = {rv, correct}; e.pl = m_look[sel]; e.pm = m_mis[sel];
    exp_q.push_back(e);
    if (!r.rn) begin
      m_look[0] = 32'h0; m_look[1] = 32'h0; m_mis[0] = 32'h0; m_mis[1] = 32'h0;
    end else begin
      if (r.lv) m_look[sel] = m_look[sel] + 32'd1;
      if (rv)   m_mis[sel]  = m_mis[sel] + 32'd1;
    end
  endtask

  task automatic test_reset();
    row_t rows [$];
    exp_t e;
    rows.push_back(lk(32'h100, 1'b0, 1'b0, 32'h104));
    rows.push_back(idle());
    foreach (rows[i]) begin
      drive(0, rows[i]); #1; e = exp_q.pop_front();
      checks++; if ({bi_if.pred_hit, bi_if.pred_taken, bi_if.pred_next_pc} !== e.lk) begin errors++; $display("FAIL reset[%0d] lookup: got %h expected %h", i, {bi_if.pred_hit, bi_if.pred_taken, bi_if.pred_next_pc}, e.lk); end
      checks++; if ({bi_if.redirect_valid, bi_if.redirect_pc} !== e.up) begin errors++; $display("FAIL reset[%0d] redirect: got %h expected %h", i, {bi_if.redirect_valid, bi_if.redirect_pc}, e.up); end
      checks++; if (bi_if.perf_lookups !== e.pl) begin errors++; $display("FAIL reset[%0d] perf_lookups: got %0d expected %0d", i, bi_if.perf_lookups, e.pl); end
      checks++; if (bi_if.perf_mispredicts !== e.pm) begin errors++; $display("FAIL reset[%0d] perf_mispredicts: got %0d expected %0d", i, bi_if.perf_mispredicts, e.pm); end
    end
  endtask

  task automatic test_bimodal(input string name, input row_t rows [$]);
    exp_t e;
    foreach (rows[i]) begin
      drive(0, rows[i]); #1; e = exp_q.pop_front();
      checks++; if ({bi_if.pred_hit, bi_if.pred_taken, bi_if.pred_next_pc} !== e.lk) begin errors++; $display("FAIL %s[%0d] lookup: got %h expected %h", name, i, {bi_if.pred_hit, bi_if.pred_taken, bi_if.pred_next_pc}, e.lk); end
      checks++; if ({bi_if.redirect_valid, bi_if.redirect_pc} !== e.up) begin errors++; $display("FAIL %s[%0d] redirect: got %h expected %h", name, i, {bi_if.redirect_valid, bi_if.redirect_pc}, e.up); end
      checks++; if (bi_if.perf_lookups !== e.pl) begin errors++; $display("FAIL %s[%0d] perf_lookups: got %0d expected %0d", name, i, bi_if.perf_lookups, e.pl); end
      checks++; if (bi_if.perf_mispredicts !== e.pm) begin errors++; $display("FAIL %s[%0d] perf_mispredicts: got %0d expected %0d", name, i, bi_if.perf_mispredicts, e.pm); end
    end
  endtask

  task automatic test_allocate();
    row_t rows [$];
    rows.push_back(up(32'h100, 1'b1, 32'h80, 32'h104));
    rows.push_back(lk(32'h100, 1'b1, 1'b1, 32'h80));
    test_bimodal("allocate", rows);
  endtask

  task automatic test_counter();
    row_t rows [$];
    rows.push_back(up(32'h100, 1'b0, 32'hDEADBEE0, 32'h80));  // ctr 2->1, redirect 0x104
    rows.push_back(lk(32'h100, 1'b1, 1'b0, 32'h104));
    rows.push_back(up(32'h100, 1'b0, 32'hDEADBEE0, 32'h104)); // ctr 1->0
    rows.push_back(up(32'h100, 1'b0, 32'hDEADBEE0, 32'h104)); // ctr stays 0
    rows.push_back(up(32'h100, 1'b1, 32'h80, 32'h104));       // ctr 0->1
    rows.push_back(lk(32'h100, 1'b1, 1'b0, 32'h104));
    rows.push_back(up(32'h100, 1'b1, 32'h80, 32'h104));       // ctr 1->2
    rows.push_back(up(32'h100, 1'b1, 32'h80, 32'h80));        // ctr 2->3
    rows.push_back(up(32'h100, 1'b1, 32'h80, 32'h80));        // ctr stays 3
    rows.push_back(up(32'h100, 1'b0, 32'hDEADBEE0, 32'h80));  // ctr 3->2
    rows.push_back(lk(32'h100, 1'b1, 1'b1, 32'h80));
    rows.push_back(up(32'h100, 1'b1, 32'h300, 32'h80));       // new target
    rows.push_back(lk(32'h100, 1'b1, 1'b1, 32'h300));
    test_bimodal("counter", rows);
  endtask

  task automatic test_alias();
    row_t rows [$];
    rows.push_back(up(32'h200, 1'b1, 32'h400, 32'h204));
    rows.push_back(lk(32'h100, 1'b0, 1'b0, 32'h104));
    rows.push_back(lk(32'h200, 1'b1, 1'b1, 32'h400));
    rows.push_back(up(32'h100, 1'b0, 32'h0, 32'h104));
    rows.push_back(lk(32'h200, 1'b1, 1'b1, 32'h400));
    test_bimodal("alias", rows);
  endtask

  task automatic test_same_cycle();
    row_t rows [$];
    rows.push_back(mk(1'b1, 32'h1000, 1'b0, 1'b0, 32'h1004, 1'b1, 32'h1000, 1'b1, 32'h2000, 32'h1004));
    rows.push_back(lk(32'h1000, 1'b1, 1'b1, 32'h2000));
    test_bimodal("same_cycle", rows);
  endtask

  task automatic test_wrap();
    row_t rows [$];
    rows.push_back(lk(32'hFFFFFFFC, 1'b0, 1'b0, 32'h0));
    rows.push_back(up(32'hFFFFFFFC, 1'b0, 32'h0, 32'h0));
    rows.push_back(up(32'hFFFFFFFC, 1'b0, 32'h0, 32'h4));
    rows.push_back(up(32'h300, 1'b1, 32'h402, 32'h304));
    rows.push_back(lk(32'h300, 1'b1, 1'b1, 32'h400));
    test_bimodal("wrap", rows);
  endtask

  task automatic test_static();
    row_t rows [$];
    exp_t e;
    rows.push_back(up(32'h40, 1'b1, 32'h10, 32'h44));
    rows.push_back(lk(32'h40, 1'b0, 1'b0, 32'h44));
    rows.push_back(idle());
    foreach (rows[i]) begin
      drive(1, rows[i]); #1; e = exp_q.pop_front();
      checks++; if ({st_if.pred_hit, st_if.pred_taken, st_if.pred_next_pc} !== e.lk) begin errors++; $display("FAIL static[%0d] lookup: got %h expected %h", i, {st_if.pred_hit, st_if.pred_taken, st_if.pred_next_pc}, e.lk); end
      checks++; if ({st_if.redirect_valid, st_if.redirect_pc} !== e.up) begin errors++; $display("FAIL static[%0d] redirect: got %h expected %h", i, {st_if.redirect_valid, st_if.redirect_pc}, e.up); end
      checks++; if (st_if.perf_lookups !== e.pl) begin errors++; $display("FAIL static[%0d] perf_lookups: got %0d expected %0d", i, st_if.perf_lookups, e.pl); end
      checks++; if (st_if.perf_mispredicts !== e.pm) begin errors++; $display("FAIL static[%0d] perf_mispredicts: got %0d expected %0d", i, st_if.perf_mispredicts, e.pm); end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows [$];
    row_t r;
    r = mk(1'b1, 32'h300, 1'b0, 1'b0, 32'h304, 1'b1, 32'h100, 1'b1, 32'h80, 32'h104);
    r.rn = 1'b0;
    rows.push_back(r);
    rows.push_back(lk(32'h300, 1'b0, 1'b0, 32'h304));
    rows.push_back(lk(32'h100, 1'b0, 1'b0, 32'h104));
    rows.push_back(lk(32'h1000, 1'b0, 1'b0, 32'h1004));
    test_bimodal("reset_mid", rows);
  endtask

  initial begin
    m_look[0] = 32'h0; m_look[1] = 32'h0; m_mis[0] = 32'h0; m_mis[1] = 32'h0;
    rst_n = 1'b0;
    set_idle_bi();
    set_idle_st();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_wrap();
    test_static();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
